// File: rtl/pixel_compositor_pkg.sv
// Shared constants for the pixel compositor: colour values, pixel width,
// counter limits and the index-width helper used by the top and its selector.
package pixel_compositor_pkg;

  localparam int unsigned PIX_W = 12;

  localparam logic [PIX_W-1:0] GREEN = 12'h0F0;
  localparam logic [PIX_W-1:0] BLACK = 12'h000;

  localparam logic [15:0] FRAME_CNT_MAX = 16'hFFFF;

  // Width able to hold 0..n (n sources plus the "background" index n).
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_compositor_priority_select.sv
// priority_select: combinational winner search over the stage-1 registers.
// Picks the active source with the highest layer value (ties to the lowest
// index) and counts how many sources are active. When no source is active
// the winner index is WIDTH, which the top maps to the background colour.
module priority_select
  import pixel_compositor_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LEVEL_W = 4,
  localparam int unsigned IDX_W  = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]         active_i,
  input  logic [WIDTH*LEVEL_W-1:0] level_i,
  output logic [IDX_W-1:0]         win_idx_o,
  output logic [IDX_W-1:0]         count_o
);

  logic [LEVEL_W-1:0] best_lvl;
  logic               found;

  // Scan from index 0 upward; a later source only takes over on a strictly
  // greater level, which leaves ties with the lowest index.
  always_comb begin
    best_lvl  = '0;
    found     = 1'b0;
    win_idx_o = IDX_W'(WIDTH);
    count_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (active_i[i]) begin
        count_o = count_o + IDX_W'(1);
        if (!found || (level_i[i*LEVEL_W +: LEVEL_W] > best_lvl)) begin
          found     = 1'b1;
          best_lvl  = level_i[i*LEVEL_W +: LEVEL_W];
          win_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: two-stage layer compositor.
// Stage 1 registers the per-source active mask, levels and pixels; stage 2
// registers the winning colour, its index and the active-source count, and
// keeps per-frame collision statistics.
// Optional feature macro: PIXEL_COLOR_KEY_EN -- adds parameter COLOR_KEY; a
// source whose pixel equals COLOR_KEY is treated as transparent (inactive).
//
// Flow control: valid-only streaming. in_valid marks a pixel slot for one
// cycle; there is no ready/backpressure, so every accepted pixel produces
// exactly one out_valid pulse two cycles later, in order, with no stalls.
// out/hit_id/collision_num hold their last value while out_valid is low.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int unsigned       WIDTH      = 4,
  parameter int unsigned       LEVEL_W    = 4,
  parameter logic [PIX_W-1:0]  BACKGROUND = GREEN
`ifdef PIXEL_COLOR_KEY_EN
  ,
  parameter logic [PIX_W-1:0]  COLOR_KEY  = BLACK
`endif
  ,
  localparam int unsigned      IDX_W      = idx_width(WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     frame_start,
  input  logic [WIDTH-1:0]         enable,
  input  logic [WIDTH*LEVEL_W-1:0] level,
  input  logic [WIDTH*PIX_W-1:0]   pixel,
  output logic [PIX_W-1:0]         out,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         hit_id,
  output logic [IDX_W-1:0]         collision_num,
  output logic [15:0]              frame_collisions
);

  // Stage 1 state
  logic                     s1_valid_q;
  logic                     s1_fs_q;
  logic [WIDTH-1:0]         s1_act_q, s1_act_d;
  logic [WIDTH*LEVEL_W-1:0] s1_lvl_q;
  logic [WIDTH*PIX_W-1:0]   s1_pix_q;

  // Stage 2 state
  logic                     out_valid_q;
  logic [PIX_W-1:0]         out_q, out_d;
  logic [IDX_W-1:0]         hit_q;
  logic [IDX_W-1:0]         cnt_q;
  logic [15:0]              run_q;
  logic [15:0]              frame_q;

  logic [IDX_W-1:0]         sel_idx;
  logic [IDX_W-1:0]         sel_cnt;
  logic                     collide;

  // Activity mask: enabled with a non-zero layer (and, when keyed, not transparent).
  always_comb begin
    s1_act_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_act_d[i] = enable[i] && (level[i*LEVEL_W +: LEVEL_W] != '0);
`ifdef PIXEL_COLOR_KEY_EN
      if (pixel[i*PIX_W +: PIX_W] == COLOR_KEY) begin
        s1_act_d[i] = 1'b0;
      end
`endif
    end
  end

  // Stage 1 register; data only loads on a valid slot, frame_start is gated by in_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_fs_q    <= 1'b0;
      s1_act_q   <= '0;
      s1_lvl_q   <= '0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_fs_q    <= in_valid & frame_start;
      if (in_valid) begin
        s1_act_q <= s1_act_d;
        s1_lvl_q <= level;
        s1_pix_q <= pixel;
      end
    end
  end

  priority_select #(
    .WIDTH   (WIDTH),
    .LEVEL_W (LEVEL_W)
  ) u_priority_select (
    .active_i  (s1_act_q),
    .level_i   (s1_lvl_q),
    .win_idx_o (sel_idx),
    .count_o   (sel_cnt)
  );

  // Colour of the winning source, or the background when the index is WIDTH.
  always_comb begin
    out_d = BACKGROUND;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        out_d = s1_pix_q[i*PIX_W +: PIX_W];
      end
    end
  end

  // A collision is two or more active sources on the same pixel.
  assign collide = (sel_cnt > IDX_W'(1));

  // Stage 2 register: outputs hold while idle; frame_start snapshots the running count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= BACKGROUND;
      hit_q       <= IDX_W'(WIDTH);
      cnt_q       <= '0;
      run_q       <= '0;
      frame_q     <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q <= out_d;
        hit_q <= sel_idx;
        cnt_q <= sel_cnt;
        if (s1_fs_q) begin
          frame_q <= run_q;
          run_q   <= collide ? 16'd1 : 16'd0;
        end else if (collide && (run_q != FRAME_CNT_MAX)) begin
          run_q <= run_q + 16'd1;
        end
      end
    end
  end

  assign out              = out_q;
  assign out_valid        = out_valid_q;
  assign hit_id           = hit_q;
  assign collision_num    = cnt_q;
  assign frame_collisions = frame_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor (WIDTH=4, LEVEL_W=4, default
// background). A reference model computes each composited pixel from the
// layering rules and queues it; a negedge process checks every output cycle
// (and the hold behaviour on idle cycles) against that queue.
module tb_pixel_compositor;

  localparam logic [11:0] BG    = 12'h0F0;
  localparam logic [11:0] KEY   = 12'h000;
  localparam int          EXP_W = 66;

  // Source 0 sits in the low bits of every packed vector.
  localparam logic [47:0] PXA = {12'hF0F, 12'hABC, 12'h123, 12'h9E7};
  localparam logic [47:0] PXB = {12'h0F0, 12'h800, 12'h00F, 12'hFFF};

  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] out;
    logic [2:0]  hit;
    logic [2:0]  coll;
    logic [15:0] fc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        frame_start;
  logic [3:0]  enable;
  logic [15:0] level;
  logic [47:0] pixel;
  logic [11:0] out;
  logic        out_valid;
  logic [2:0]  hit_id;
  logic [2:0]  collision_num;
  logic [15:0] frame_collisions;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  pixel_compositor #(
    .WIDTH   (4),
    .LEVEL_W (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .frame_start      (frame_start),
    .enable           (enable),
    .level            (level),
    .pixel            (pixel),
    .out              (out),
    .out_valid        (out_valid),
    .hit_id           (hit_id),
    .collision_num    (collision_num),
    .frame_collisions (frame_collisions)
  );

  // ---------------- scoreboard / model ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               m_run = 0;
  int               m_fc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner = lowest-indexed active source among those at the maximum level.
  task automatic model_push(input logic fs, input logic [3:0] en, input logic [15:0] lv,
                            input logic [47:0] px, output exp_t e);
    logic act[4];
    int   mx;
    int   cnt;
    mx  = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      act[i] = en[i] && (lv[i*4 +: 4] != 4'd0);
`ifdef PIXEL_COLOR_KEY_EN
      if (px[i*12 +: 12] == KEY) act[i] = 1'b0;
`endif
      if (act[i]) begin
        cnt++;
        if (int'(lv[i*4 +: 4]) > mx) mx = int'(lv[i*4 +: 4]);
      end
    end
    e.out = BG;
    e.hit = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (act[i] && (int'(lv[i*4 +: 4]) == mx)) begin
        e.hit = 3'(i);
        e.out = px[i*12 +: 12];
      end
    end
    e.coll = 3'(cnt);
    if (fs) begin
      m_fc  = m_run;
      m_run = (cnt >= 2) ? 1 : 0;
    end else if ((cnt >= 2) && (m_run < 65535)) begin
      m_run++;
    end
    e.fc  = 16'(m_fc);
    e.cyc = 32'(cyc + 2);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic v, input logic fs, input logic [3:0] en,
                       input logic [15:0] lv, input logic [47:0] px);
    exp_t e;
    in_valid    = v;
    frame_start = fs;
    enable      = en;
    level       = lv;
    pixel       = px;
    if (v) model_push(fs, en, lv, px, e);
  endtask

  task automatic send(input logic v, input logic fs, input logic [3:0] en,
                      input logic [15:0] lv, input logic [47:0] px);
    @(posedge clk);
    #1;
    apply(v, fs, en, lv, px);
  endtask

  task automatic send_e(input logic fs, input logic [3:0] en, input logic [15:0] lv,
                        input logic [47:0] px, output exp_t e);
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    frame_start = fs;
    enable      = en;
    level       = lv;
    pixel       = px;
    model_push(fs, en, lv, px, e);
  endtask

  task automatic idle();
    send(1'b0, 1'b0, 4'b0000, 16'h0000, PXA);
  endtask

  // Two idle slots later the pixel sent just before is on the outputs.
  task automatic dut_lit(input string tag, input logic [11:0] eo, input int eh,
                         input int ec, input int efc);
    idle();
    idle();
    @(negedge clk);
    check({tag, "_ov"},   32'(out_valid),        1);
    check({tag, "_out"},  32'(out),              32'(eo));
    check({tag, "_hit"},  32'(hit_id),           eh);
    check({tag, "_coll"}, 32'(collision_num),    ec);
    check({tag, "_fc"},   32'(frame_collisions), efc);
  endtask

  // ---------------- compare process ----------------
  logic [11:0] last_out  = BG;
  logic [2:0]  last_hit  = 3'd4;
  logic [2:0]  last_coll = 3'd0;
  logic [15:0] last_fc   = 16'd0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b0) begin
      check("rst_out_valid", 32'(out_valid),        0);
      check("rst_out",       32'(out),              32'(BG));
      check("rst_hit",       32'(hit_id),           4);
      check("rst_coll",      32'(collision_num),    0);
      check("rst_fc",        32'(frame_collisions), 0);
      last_out  = BG;
      last_hit  = 3'd4;
      last_coll = 3'd0;
      last_fc   = 16'd0;
    end else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 0);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("latency", 32'(cyc),              e.cyc);
        check("out",     32'(out),              32'(e.out));
        check("hit_id",  32'(hit_id),           32'(e.hit));
        check("coll",    32'(collision_num),    32'(e.coll));
        check("fc",      32'(frame_collisions), 32'(e.fc));
        last_out  = e.out;
        last_hit  = e.hit;
        last_coll = e.coll;
        last_fc   = e.fc;
      end
    end else begin
      check("hold_valid", 32'(out_valid),        0);
      check("hold_out",   32'(out),              32'(last_out));
      check("hold_hit",   32'(hit_id),           32'(last_hit));
      check("hold_coll",  32'(collision_num),    32'(last_coll));
      check("hold_fc",    32'(frame_collisions), 32'(last_fc));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [3:0]  COL_EN   = 4'b1111;
  localparam logic [15:0] COL_LV   = 16'h1100;   // sources 2,3 at level 1
  localparam logic [3:0]  NOCOL_EN = 4'b0001;
  localparam logic [15:0] NOCOL_LV = 16'h0003;   // source 0 only

  logic [3:0]  tab_en[8];
  logic [15:0] tab_lv[8];

  initial begin
    exp_t e;
    reset_n     = 1'b1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    enable      = 4'b0000;
    level       = 16'h0000;
    pixel       = PXA;
    #2 reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n  = 1'b1;
    idle();

    // Two of four sources enabled: higher level wins.
    send_e(1'b0, 4'b0110, 16'h2530, PXA, e);
    check("m032_hit", 32'(e.hit), 2);
    check("m032_coll", 32'(e.coll), 2);
    dut_lit("v032", 12'hABC, 2, 2, 0);

    // Tie at level 4 between sources 0 and 1 goes to source 0.
    send_e(1'b0, 4'b1111, 16'h0144, PXA, e);
    check("m033_hit", 32'(e.hit), 0);
    check("m033_coll", 32'(e.coll), 3);
    dut_lit("v033", 12'h9E7, 0, 3, 0);

    // Nothing enabled: background.
    send_e(1'b0, 4'b0000, 16'hFFFF, PXA, e);
    check("m034_out", 32'(e.out), 32'(BG));
    dut_lit("v034", BG, 4, 0, 0);

    // Back-to-back vectors, no gaps.
    tab_en = '{4'b1111, 4'b1000, 4'b1010, 4'b0000, 4'b1111, 4'b0101, 4'b1100, 4'b0011};
    tab_lv = '{16'hFFFF, 16'hF000, 16'h9090, 16'hFFFF, 16'h0000, 16'h1E2F, 16'h8F00, 16'h0010};
    for (int i = 0; i < 8; i++) begin
      send_e(1'b0, tab_en[i], tab_lv[i], (i % 2 == 0) ? PXA : PXB, e);
      if (i == 0) begin
        check("m_all15_hit", 32'(e.hit), 0);
        check("m_all15_coll", 32'(e.coll), 4);
      end
    end
    idle();

    // frame_start without in_valid must not be taken.
    send(1'b0, 1'b1, 4'b1111, 16'hFFFF, PXA);
    idle();
    idle();

    // Frame of 10 pixels, collisions at positions 2, 5 and 8, idle gaps mixed in.
    for (int p = 0; p < 10; p++) begin
      if ((p == 2) || (p == 5) || (p == 8))
        send(1'b1, (p == 0), COL_EN, COL_LV, PXB);
      else
        send(1'b1, (p == 0), NOCOL_EN, NOCOL_LV, PXB);
      if (p % 3 == 1) idle();
    end
    send_e(1'b1, COL_EN, COL_LV, PXA, e);
    check("m035_fc", 32'(e.fc), 3);
    dut_lit("v035", 12'hABC, 2, 2, 3);

    // The previous frame_start pixel itself collided, so the next frame counts 1.
    send_e(1'b1, NOCOL_EN, NOCOL_LV, PXA, e);
    check("m_restart_fc", 32'(e.fc), 1);
    dut_lit("v_restart", 12'h9E7, 0, 1, 1);

    // Reset for one cycle with two pixels in flight.
    send(1'b1, 1'b0, COL_EN, COL_LV, PXA);
    send(1'b1, 1'b0, COL_EN, COL_LV, PXA);
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_run = 0;
    m_fc  = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // Input on the very first edge after release.
    apply(1'b1, 1'b1, NOCOL_EN, NOCOL_LV, PXA);
    dut_lit("v_post_rst", 12'h9E7, 0, 1, 0);
    send(1'b1, 1'b0, COL_EN, COL_LV, PXB);
    send(1'b1, 1'b0, COL_EN, COL_LV, PXB);
    send_e(1'b1, NOCOL_EN, NOCOL_LV, PXB, e);
    check("m_post_rst_fc", 32'(e.fc), 2);
    idle();

    // Source 3 at level 7 with a key-coloured pixel, source 1 at level 2.
    send_e(1'b0, 4'b1010, 16'h7020, {12'h000, 12'hABC, 12'h123, 12'h9E7}, e);
`ifdef PIXEL_COLOR_KEY_EN
    check("m037_hit", 32'(e.hit), 1);
    check("m037_coll", 32'(e.coll), 1);
    dut_lit("v037", 12'h123, 1, 1, 2);
`else
    check("m037_nokey_hit", 32'(e.hit), 3);
    dut_lit("v037_nokey", 12'h000, 3, 2, 2);
`endif

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) idle();
    check("drain", 32'(exp_q.size()), 0);
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of source components (1..32).
REQ-002 SHALL have parameter LEVEL_W, default 4, meaning width of each layer value.
REQ-003 SHALL have parameter BACKGROUND, default GREEN, meaning 12-bit colour output when no source wins.
REQ-004 SHALL have port clk  in  1  meaning system clock; all state is rising-edge.
REQ-005 SHALL have port reset_n  in  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid  in  1  meaning the input pixel slot is present this cycle.
REQ-007 SHALL have port frame_start  in  1  meaning the first pixel of a frame; qualified by in_valid.
REQ-008 SHALL have port enable  in  WIDTH  meaning per-source drawing flag.
REQ-009 SHALL have port level  in  WIDTH*LEVEL_W  meaning packed per-source layer values; source i is at bits [i*LEVEL_W +: LEVEL_W].
REQ-010 SHALL have port pixel  in  WIDTH*12  meaning packed per-source 12-bit RGB values.
REQ-011 SHALL have port out  out  12  meaning composited pixel.
REQ-012 SHALL have port out_valid  out  1  meaning out, hit_id and collision_num are valid.
REQ-013 SHALL have port hit_id  out  $clog2(WIDTH+1)  meaning winning source index, or WIDTH when background is output.
REQ-014 SHALL have port collision_num  out  $clog2(WIDTH+1)  meaning count of active sources at this pixel.
REQ-015 SHALL have port frame_collisions  out  16  meaning count of pixels in the previous complete frame with collision_num >= 2.

Function
REQ-016 SHALL treat source i as active iff enable[i]=1 and level[i]!=0.
REQ-017 SHALL select the active source with the highest level; ties SHALL go to the lowest index.
REQ-018 SHALL output BACKGROUND with hit_id=WIDTH when no source is active.
REQ-019 SHALL use a two-stage pipeline: stage 1 registers the active mask, levels and pixels; stage 2 registers out, hit_id and collision_num.
REQ-020 SHALL assert out_valid exactly 2 cycles after in_valid, with one output per input and no stalls; back-to-back inputs SHALL give back-to-back outputs.
REQ-021 SHALL hold out, hit_id and collision_num while out_valid=0.
REQ-022 SHALL keep a 16-bit running counter that increments in stage 2 for each valid pixel with collision_num>=2, saturating at 16'hFFFF.
REQ-023 When a valid frame_start pixel reaches stage 2, SHALL copy the running counter into frame_collisions and restart the running counter at 0 or 1 depending on that pixel's own collision.
REQ-024 SHALL ignore frame_start when in_valid=0.

Reset
REQ-025 While reset_n=0, out=BACKGROUND, hit_id=WIDTH, collision_num=0, out_valid=0, frame_collisions=0, running counter=0, and all stage-1 valid bits SHALL be 0.
REQ-026 SHALL drop any pixel in flight when reset is asserted mid-pipeline; no out_valid pulse for it SHALL follow deassertion.
REQ-027 SHALL accept input on the first rising edge after reset_n is deasserted.

Configuration
REQ-028 With macro PIXEL_COLOR_KEY_EN defined, SHALL add parameter COLOR_KEY (default 12'h000), and a source whose pixel equals COLOR_KEY SHALL be treated as inactive for selection and for collision counting.
REQ-029 Without PIXEL_COLOR_KEY_EN, SHALL have no COLOR_KEY parameter, and pixel values SHALL NOT affect activity.

Structure
REQ-030 SHALL take the colour constants (BACKGROUND default, GREEN) from the shared constants header.
REQ-031 SHALL put the stage-2 combinational max/index/popcount logic in one sub-module, priority_select, parametrised by WIDTH and LEVEL_W.

Verification
REQ-032 WIDTH=4; enable=4'b0110, levels {0,3,5,2} (source 0 first) -> 2 cycles later out=pixel[2], hit_id=2, collision_num=2.
REQ-033 enable=4'b1111, levels {4,4,1,0} -> hit_id=0 (tie to lowest index), collision_num=3.
REQ-034 enable=0 for every source -> out=BACKGROUND, hit_id=4, collision_num=0.
REQ-035 Frame of 10 pixels with 3 collisions, then frame_start -> frame_collisions=3 two cycles after the frame_start input.
REQ-036 reset_n pulsed low for 1 cycle while 2 pixels are in flight -> out_valid stays 0 for them, and all outputs return to their reset values.
REQ-037 PIXEL_COLOR_KEY_EN defined, COLOR_KEY=12'h000; source 3 has level 7 and pixel 12'h000, source 1 has level 2 -> hit_id=1, collision_num=1.
